// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: the E-stage control bundle, its bubble value
// and the ResultSrc encoding used by the writeback mux.
package pipe_pkg;

    // Widest ALU op supported; narrower ALU_CTRL_W builds zero-extend into this field.
    localparam int ALU_CTRL_MAX_W = 8;

    localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

    typedef struct packed {
        logic                      reg_write;
        logic [1:0]                result_src;
        logic                      mem_write;
        logic                      jump;
        logic                      branch;
        logic [ALU_CTRL_MAX_W-1:0] alu_control;
        logic                      alu_src;
        logic                      jalr_ctrl;
    } ctrl_e_t;

    localparam ctrl_e_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter for per-stage performance statistics; holds at all-ones.
module pipe_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/decode_exec_pipe_reg.sv
// Decode->Execute pipeline register with stall, flush-to-bubble and valid bit.
// Optional saturating bubble/stall counters are built when PIPE_PERF_CNT_EN is defined.
module decode_exec_pipe_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ALU_CTRL_W = 3,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StallE,
    input  logic                  FlushE,
    input  logic                  ValidD,
    input  logic                  RegWriteD,
    input  logic                  MemWriteD,
    input  logic                  JumpD,
    input  logic                  BranchD,
    input  logic                  ALUSrcD,
    input  logic                  JALRctrlD,
    input  logic [1:0]            ResultSrcD,
    input  logic [ALU_CTRL_W-1:0] ALUControlD,
    input  logic [WIDTH-1:0]      RD1D,
    input  logic [WIDTH-1:0]      RD2D,
    input  logic [WIDTH-1:0]      PCD,
    input  logic [WIDTH-1:0]      ImmExtD,
    input  logic [WIDTH-1:0]      PCPlus4D,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] RdD,
    output logic                  ValidE,
    output logic                  RegWriteE,
    output logic                  MemWriteE,
    output logic                  JumpE,
    output logic                  BranchE,
    output logic                  ALUSrcE,
    output logic                  JALRctrlE,
    output logic [1:0]            ResultSrcE,
    output logic [ALU_CTRL_W-1:0] ALUControlE,
    output logic [WIDTH-1:0]      RD1E,
    output logic [WIDTH-1:0]      RD2E,
    output logic [WIDTH-1:0]      PCE,
    output logic [WIDTH-1:0]      ImmExtE,
    output logic [WIDTH-1:0]      PCPlus4E,
    output logic [REG_ADDR_W-1:0] Rs1E,
    output logic [REG_ADDR_W-1:0] Rs2E,
    output logic [REG_ADDR_W-1:0] RdE,
    output logic [CNT_W-1:0]      BubbleCntE,
    output logic [CNT_W-1:0]      StallCntE
);

    ctrl_e_t ctrl_d;
    ctrl_e_t ctrl_q;

    always_comb begin
        ctrl_d             = CTRL_BUBBLE;
        ctrl_d.reg_write   = RegWriteD;
        ctrl_d.result_src  = ResultSrcD;
        ctrl_d.mem_write   = MemWriteD;
        ctrl_d.jump        = JumpD;
        ctrl_d.branch      = BranchD;
        ctrl_d.alu_control = ALU_CTRL_MAX_W'(ALUControlD);
        ctrl_d.alu_src     = ALUSrcD;
        ctrl_d.jalr_ctrl   = JALRctrlD;
    end

    // Flush outranks stall so the load-use case (stall F/D, bubble E) yields a NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ValidE   <= 1'b0;
            ctrl_q   <= CTRL_BUBBLE;
            RD1E     <= '0;
            RD2E     <= '0;
            PCE      <= '0;
            ImmExtE  <= '0;
            PCPlus4E <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
        end else if (FlushE) begin
            ValidE   <= 1'b0;
            ctrl_q   <= CTRL_BUBBLE;
            RD1E     <= '0;
            RD2E     <= '0;
            PCE      <= '0;
            ImmExtE  <= '0;
            PCPlus4E <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
        end else if (!StallE) begin
            ValidE   <= ValidD;
            ctrl_q   <= ctrl_d;
            RD1E     <= RD1D;
            RD2E     <= RD2D;
            PCE      <= PCD;
            ImmExtE  <= ImmExtD;
            PCPlus4E <= PCPlus4D;
            Rs1E     <= Rs1D;
            Rs2E     <= Rs2D;
            RdE      <= RdD;
        end
    end

    assign RegWriteE   = ctrl_q.reg_write;
    assign ResultSrcE  = ctrl_q.result_src;
    assign MemWriteE   = ctrl_q.mem_write;
    assign JumpE       = ctrl_q.jump;
    assign BranchE     = ctrl_q.branch;
    assign ALUControlE = ALU_CTRL_W'(ctrl_q.alu_control);
    assign ALUSrcE     = ctrl_q.alu_src;
    assign JALRctrlE   = ctrl_q.jalr_ctrl;

`ifdef PIPE_PERF_CNT_EN
    pipe_sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (FlushE),
        .count (BubbleCntE)
    );

    pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (StallE & ~FlushE),
        .count (StallCntE)
    );
`else
    assign BubbleCntE = '0;
    assign StallCntE  = '0;
`endif

endmodule

// File: doc/decode_exec_pipe_reg.md
Name: decode_exec_pipe_reg

Overview:
Parametrised Decode→Execute pipeline register, the next generation of the plain ID/EX latch.
- Adds asynchronous active-low reset, stall (hold), flush (bubble insertion) and a per-stage valid bit.
- Carries source-register addresses for the forwarding unit, and has configurable data, ALU-control and register-address widths.
- Sits between decode/register-file read and the ALU stage; driven by the hazard unit.

Parameters:
WIDTH, 32, datapath width (RD1/RD2/PC/Imm/PC+4)
ALU_CTRL_W, 3, ALUControl width (4 for extended ALU ops)
REG_ADDR_W, 5, register index width (Rs1/Rs2/Rd)
CNT_W, 32, performance counter width (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
StallE  in  1  hold all E outputs this cycle
FlushE  in  1  load a bubble this cycle
ValidD  in  1  decode stage holds a real instruction
RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, JALRctrlD  in  1 each  decode control
ResultSrcD  in  2  result mux select
ALUControlD  in  ALU_CTRL_W  ALU op
RD1D, RD2D, PCD, ImmExtD, PCPlus4D  in  WIDTH each  decode data
Rs1D, Rs2D, RdD  in  REG_ADDR_W each  register indices
ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JALRctrlE  out  1 each  registered copies
ResultSrcE  out  2; ALUControlE  out  ALU_CTRL_W
RD1E, RD2E, PCE, ImmExtE, PCPlus4E  out  WIDTH each
Rs1E, Rs2E, RdE  out  REG_ADDR_W each
BubbleCntE, StallCntE  out  CNT_W each  performance counters (optional feature)

Behaviour:
- All outputs are registered; latency is one clk from D input to E output. There is no combinational path input→output.
- Reset: rst_n low asynchronously forces every output to 0, including ValidE, all control, all data and counters. Release is synchronous to the next clk edge, and the first capture occurs at the first rising edge with rst_n high.
- Per-edge priority is reset > FlushE > StallE > load.
- Load: when FlushE=0 and StallE=0, capture every D input, including ValidD.
- Stall: when StallE=1 and FlushE=0, every E output holds its previous value.
- Flush: when FlushE=1, regardless of StallE, every E output is cleared to 0. This includes ValidE, RegWriteE, MemWriteE, JumpE, BranchE, data and indices. The result is a canonical NOP bubble with no architectural side effects.
- FlushE=1 with StallE=1: flush wins. This is the load-use case in which the hazard unit stalls F/D and bubbles E.
- Control and data fields are captured unconditionally on load, even when ValidD=0. Downstream stages qualify side effects only by RegWriteE/MemWriteE, so ValidD=0 with RegWriteD=1 passes through as-is.
- Reset mid-stall or mid-flush: outputs go to 0 immediately, and stall/flush state carries no memory.
- Width rules: there is no arithmetic on the datapath. All fields are bit-exact copies.

Optional Feature:
Macro PIPE_PERF_CNT_EN.
- Defined:
  - BubbleCntE increments on every edge where FlushE=1.
  - StallCntE increments on every edge where StallE=1 and FlushE=0.
  - Both counters saturate at all-ones and do not wrap.
  - Both reset to 0 on rst_n low.
- Undefined: BubbleCntE and StallCntE are tied to constant 0, and no counter flops are instantiated.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef ctrl_e_t, a packed struct of RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc and JALRctrl;
  - localparam CTRL_BUBBLE, all-zero, the bubble value;
  - ResultSrc encoding constants (ALU, MEM, PC4).
- Sub-module pipe_sat_counter (width CNT_W; inc, count) is instantiated twice under PIPE_PERF_CNT_EN. It is reused by the other stage registers.

Test Plan:
- Reset: hold rst_n=0 with D inputs randomised, then release. Required: all outputs 0 throughout reset, including asynchronously mid-cycle, and the first captured value appears one edge after release.
- Load: PCD=0x0000_0040, RD1D=0xDEAD_BEEF, RdD=5, RegWriteD=1, ValidD=1, stall/flush 0. Required: the next edge shows PCE=0x40, RD1E=0xDEADBEEF, RdE=5, RegWriteE=1, ValidE=1.
- Stall: after the load above, StallE=1 for 3 cycles while PCD changes to 0x44, 0x48, 0x4C. Required: PCE stays 0x40 for all 3 cycles, then becomes 0x4C on the edge after StallE drops.
- Flush: FlushE=1 with MemWriteD=1 and PCD=0x80. Required: the next edge shows all E outputs 0, including MemWriteE=0 and ValidE=0.
- Simultaneous: StallE=1 and FlushE=1 together. Required: the bubble is loaded (all 0), not held. With PIPE_PERF_CNT_EN, BubbleCntE increments by 1 and StallCntE is unchanged.
- Counter saturation (PIPE_PERF_CNT_EN, CNT_W=4): hold StallE=1 for 20 cycles. Required: StallCntE climbs to 15 and stays there; then rst_n=0 returns it to 0.
